movimenta_tiros: RTL and testbench
==================================

// Module: movimenta_tiros
// PURPOSE
// Shot store and shot-movement stage. It sits directly upstream of the shot/asteroid comparison control unit.
// Holds N_TIROS shot slots, each with a position, a direction and a rendered flag. Spawns new shots at the ship.
// On request, advances every rendered shot one grid cell and retires shots that leave the field.
// Provides a combinational read port indexed by the comparator's shot counter, and accepts slot-clear (destroy) requests from the comparator.
// PARAMETERS
// N_TIROS        4   number of shot slots (power of 2, >=2)
// LARGURA_COORD  4   bits per coordinate; field is 0..2^LARGURA_COORD-1 on each axis
// PORTS
// clock               in   1                  system clock, rising edge
// reset               in   1                  asynchronous, active-low (0 = reset)
// iniciar_movimento   in   1                  level request to move all shots; held until fim_movimento
// novo_tiro           in   1                  request to spawn a shot
// posicao_nave        in   2*LARGURA_COORD    {x,y} ship position; x in upper half
// direcao_nave        in   2                  00 up(y-1), 01 right(x+1), 10 down(y+1), 11 left(x-1)
// endereco_leitura    in   log2(N_TIROS)      slot index for the read and clear ports
// apaga_tiro          in   1                  clear rendered flag of slot endereco_leitura
// posicao_tiro        out  2*LARGURA_COORD    {x,y} of slot endereco_leitura (combinational)
// tiro_renderizado    out  1                  rendered flag of slot endereco_leitura (combinational)
// tiros_ativos        out  log2(N_TIROS)+1    popcount of rendered flags (combinational)
// fim_movimento       out  1                  1-cycle pulse: movement pass complete
// tiro_descartado     out  1                  1-cycle pulse: spawn rejected, no free slot
// db_estado           out  4                  debug state code
// BEHAVIOUR
// - Reset (async, reset=0):
//   - All slots: flag=0, position=0, direction=00.
//   - Index counter = 0; state = INICIO.
//   - fim_movimento = 0, tiro_descartado = 0.
// - States and db_estado codes: INICIO 0, ESPERA 1, CARREGA 2, PREPARA 3, MOVE 4, INCREMENTA 5, FIM 6.
//   Any other encoding -> INICIO. Moore outputs only.
// - State transitions:
//   - INICIO -> ESPERA.
//   - ESPERA: novo_tiro=1 -> CARREGA (priority); else iniciar_movimento=1 -> PREPARA; else stay.
//   - CARREGA: writes the lowest-index slot with flag=0:
//     position = posicao_nave, direction = direcao_nave, flag = 1.
//     If no slot is free: no write; tiro_descartado=1 in this state. Then -> ESPERA.
//     Inputs are sampled at the ESPERA->CARREGA edge.
//   - PREPARA: index <= 0 -> MOVE.
//   - MOVE: slot[index] with flag=1 steps one cell in its direction.
//     If the step would cross a field edge, flag <= 0 and the position is left unchanged:
//       - y=0 and up
//       - x=MAX and right
//       - y=MAX and down
//       - x=0 and left
//     Slots with flag=0 are untouched. Then -> INCREMENTA.
//   - INCREMENTA: index==N_TIROS-1 -> FIM; else index <= index+1 -> MOVE.
//   - FIM: fim_movimento=1 -> ESPERA.
// - Latency: iniciar_movimento sampled in ESPERA -> fim_movimento high exactly 2*N_TIROS+2 cycles later.
//   A spawn takes 2 cycles, ESPERA to ESPERA.
// - Clear port: apaga_tiro=1 clears slot[endereco_leitura].flag at the clock edge, in any state.
//   Simultaneous apaga_tiro and a MOVE write to the same slot: the clear wins (flag=0).
//   CARREGA free-slot selection uses the flags before this edge's clear.
// - Read port: purely combinational from registered slot state; no added latency.
// - Arithmetic: coordinates are unsigned LARGURA_COORD bits and never wrap.
//   Edge detection happens before the add or subtract.
// - iniciar_movimento held high after FIM starts a new pass. The caller drops it on seeing fim_movimento.
// - Reset mid-pass: the pass is aborted and all shots are cleared. No fim_movimento is issued.
// TESTING
// 1. Reset, then novo_tiro with pos (5,5), dir 00 -> slot0 flag=1, posicao_tiro(addr0)=(5,5), tiros_ativos=1.
// 2. Continue with iniciar_movimento=1 -> fim_movimento pulses 10 cycles later (N=4); slot0=(5,4); other slots still flag=0.
// 3. Shot at (0,3) dir 11, and a shot at (15,7) dir 01 -> after one pass both flags=0, tiros_ativos=0, positions unchanged.
// 4. Spawn 4 shots, then a 5th novo_tiro -> tiro_descartado=1 for 1 cycle; slots unchanged; tiros_ativos=4.
// 5. apaga_tiro with endereco_leitura=2 on the MOVE cycle of slot 2 -> slot2 flag=0 after the pass; the other slots moved.
// 6. reset=0 for 1 cycle during MOVE of slot 1 -> all flags 0, fim_movimento never pulses, db_estado=1 two cycles after release.

Source files
------------

// File: rtl/movimenta_tiros_if.sv
// Bundles the shot-store control, spawn, read/clear and status signals.
// master = the control unit driving requests; slave = the shot store.
interface movimenta_tiros_if #(
  parameter int N_TIROS       = 4,
  parameter int LARGURA_COORD = 4
);
  localparam int W_IDX = $clog2(N_TIROS);

  logic                       iniciar_movimento;
  logic                       novo_tiro;
  logic [2*LARGURA_COORD-1:0] posicao_nave;
  logic [1:0]                 direcao_nave;
  logic [W_IDX-1:0]           endereco_leitura;
  logic                       apaga_tiro;
  logic [2*LARGURA_COORD-1:0] posicao_tiro;
  logic                       tiro_renderizado;
  logic [W_IDX:0]             tiros_ativos;
  logic                       fim_movimento;
  logic                       tiro_descartado;
  logic [3:0]                 db_estado;

  modport master (
    output iniciar_movimento, novo_tiro, posicao_nave, direcao_nave,
           endereco_leitura, apaga_tiro,
    input  posicao_tiro, tiro_renderizado, tiros_ativos, fim_movimento,
           tiro_descartado, db_estado
  );

  modport slave (
    input  iniciar_movimento, novo_tiro, posicao_nave, direcao_nave,
           endereco_leitura, apaga_tiro,
    output posicao_tiro, tiro_renderizado, tiros_ativos, fim_movimento,
           tiro_descartado, db_estado
  );
endinterface

// File: rtl/movimenta_tiros.sv
// Shot store: spawns shots at the ship, steps every live shot one cell per pass,
// retires shots leaving the field, and serves a combinational read/clear port.
module movimenta_tiros #(
  parameter int N_TIROS       = 4,
  parameter int LARGURA_COORD = 4
) (
  input  logic              clock,
  input  logic              reset,
  movimenta_tiros_if.slave  bus
);
  localparam int W_IDX = $clog2(N_TIROS);
  localparam int W_C   = LARGURA_COORD;
  localparam logic [W_C-1:0]   COORD_MAX = '1;
  localparam logic [W_IDX-1:0] IDX_LAST  = W_IDX'(N_TIROS - 1);

  localparam logic [3:0] INICIO     = 4'd0;
  localparam logic [3:0] ESPERA     = 4'd1;
  localparam logic [3:0] CARREGA    = 4'd2;
  localparam logic [3:0] PREPARA    = 4'd3;
  localparam logic [3:0] MOVE       = 4'd4;
  localparam logic [3:0] INCREMENTA = 4'd5;
  localparam logic [3:0] FIM        = 4'd6;

  logic [3:0]       state, state_next;
  logic [W_IDX-1:0] idx;

  logic [W_C-1:0]   pos_x [N_TIROS];
  logic [W_C-1:0]   pos_y [N_TIROS];
  logic [1:0]       dir   [N_TIROS];
  logic [N_TIROS-1:0] flag;

  logic [W_C-1:0]   nave_x, nave_y;
  logic [1:0]       nave_dir;

  logic             free_found;
  logic [W_IDX-1:0] free_idx;
  logic             at_edge;
  logic [W_C-1:0]   next_x, next_y;
  logic [W_IDX:0]   active_count;

  // Lowest-index free slot: scanning downward lets the lowest hit overwrite.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = N_TIROS - 1; i >= 0; i--) begin
      if (!flag[i]) begin
        free_found = 1'b1;
        free_idx   = W_IDX'(i);
      end
    end
  end

  // Edge test is done on the current coordinate, before any arithmetic.
  always_comb begin
    at_edge = 1'b0;
    next_x  = pos_x[idx];
    next_y  = pos_y[idx];
    case (dir[idx])
      2'b00: begin at_edge = (pos_y[idx] == '0);        next_y = pos_y[idx] - W_C'(1); end
      2'b01: begin at_edge = (pos_x[idx] == COORD_MAX); next_x = pos_x[idx] + W_C'(1); end
      2'b10: begin at_edge = (pos_y[idx] == COORD_MAX); next_y = pos_y[idx] + W_C'(1); end
      default: begin at_edge = (pos_x[idx] == '0);      next_x = pos_x[idx] - W_C'(1); end
    endcase
  end

  always_comb begin
    state_next = INICIO;
    case (state)
      INICIO:     state_next = ESPERA;
      ESPERA:     if (bus.novo_tiro)              state_next = CARREGA;
                  else if (bus.iniciar_movimento) state_next = PREPARA;
                  else                            state_next = ESPERA;
      CARREGA:    state_next = ESPERA;
      PREPARA:    state_next = MOVE;
      MOVE:       state_next = INCREMENTA;
      INCREMENTA: state_next = (idx == IDX_LAST) ? FIM : MOVE;
      FIM:        state_next = ESPERA;
      default:    state_next = INICIO;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= INICIO;
      idx   <= '0;
    end else begin
      state <= state_next;
      if (state == PREPARA)                          idx <= '0;
      else if (state == INCREMENTA && idx != IDX_LAST) idx <= idx + W_IDX'(1);
    end
  end

  // Ship position/direction are captured on the ESPERA->CARREGA edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nave_x   <= '0;
      nave_y   <= '0;
      nave_dir <= 2'b00;
    end else if (state == ESPERA && bus.novo_tiro) begin
      nave_x   <= bus.posicao_nave[2*W_C-1:W_C];
      nave_y   <= bus.posicao_nave[W_C-1:0];
      nave_dir <= bus.direcao_nave;
    end
  end

  // NOTE: the slot arrays are small register files that must come out of reset
  // empty, so they sit under the async reset rather than being left uninitialised.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_TIROS; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
        dir[i]   <= 2'b00;
      end
      flag <= '0;
    end else begin
      if (state == CARREGA && free_found) begin
        pos_x[free_idx] <= nave_x;
        pos_y[free_idx] <= nave_y;
        dir[free_idx]   <= nave_dir;
        flag[free_idx]  <= 1'b1;
      end
      if (state == MOVE && flag[idx]) begin
        if (at_edge) begin
          flag[idx] <= 1'b0;
        end else begin
          pos_x[idx] <= next_x;
          pos_y[idx] <= next_y;
        end
      end
      // NOTE: the clear is the last assignment to flag, so it overrides any
      // move or spawn write to the same slot on this edge.
      if (bus.apaga_tiro) flag[bus.endereco_leitura] <= 1'b0;
    end
  end

  always_comb begin
    active_count = '0;
    for (int i = 0; i < N_TIROS; i++)
      active_count = active_count + {{W_IDX{1'b0}}, flag[i]};
  end

  assign bus.posicao_tiro     = {pos_x[bus.endereco_leitura], pos_y[bus.endereco_leitura]};
  assign bus.tiro_renderizado = flag[bus.endereco_leitura];
  assign bus.tiros_ativos     = active_count;
  assign bus.fim_movimento    = (state == FIM);
  assign bus.tiro_descartado  = (state == CARREGA) && !free_found;
  assign bus.db_estado        = state;
endmodule

// File: tb/tb_movimenta_tiros.sv
// Directed bench for movimenta_tiros: spawn, move pass, edge retirement,
// full-store rejection, clear-during-move and mid-pass reset.
module tb_movimenta_tiros;
  int n_cmp = 0;
  int n_bad = 0;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  movimenta_tiros_if #(.N_TIROS(4), .LARGURA_COORD(4)) bus ();

  movimenta_tiros #(.N_TIROS(4), .LARGURA_COORD(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.iniciar_movimento = 1'b0;
    bus.novo_tiro         = 1'b0;
    bus.posicao_nave      = '0;
    bus.direcao_nave      = 2'b00;
    bus.endereco_leitura  = '0;
    bus.apaga_tiro        = 1'b0;
  endtask

  // Reset for one cycle, then leave the DUT sitting in ESPERA at a negedge.
  task automatic do_reset();
    @(negedge clock); reset = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); @(posedge clock); @(negedge clock);
  endtask

  task automatic spawn(input logic [3:0] x, input logic [3:0] y, input logic [1:0] d,
                       output logic desc, output logic [3:0] st);
    @(negedge clock);
    bus.novo_tiro    = 1'b1;
    bus.posicao_nave = {x, y};
    bus.direcao_nave = d;
    @(posedge clock); @(negedge clock);
    bus.novo_tiro    = 1'b0;
    bus.posicao_nave = 8'hAA;
    bus.direcao_nave = ~d;
    desc = bus.tiro_descartado;
    st   = bus.db_estado;
    @(posedge clock); @(negedge clock);
  endtask

  // Raises iniciar_movimento and reports the cycle on which fim_movimento is seen (-1 = never).
  task automatic run_pass(output int lat);
    @(negedge clock);
    bus.iniciar_movimento = 1'b1;
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clock); @(negedge clock);
      if (bus.fim_movimento) begin lat = c; break; end
    end
    bus.iniciar_movimento = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #12;
    n_cmp++; if (bus.db_estado !== 4'd0) begin n_bad++; $display("FAIL reset_state: got %0d required 0", bus.db_estado); end
    n_cmp++; if (bus.fim_movimento !== 1'b0) begin n_bad++; $display("FAIL reset_fim: got %b required 0", bus.fim_movimento); end
    n_cmp++; if (bus.tiro_descartado !== 1'b0) begin n_bad++; $display("FAIL reset_desc: got %b required 0", bus.tiro_descartado); end
    n_cmp++; if (bus.tiros_ativos !== 3'd0) begin n_bad++; $display("FAIL reset_ativos: got %0d required 0", bus.tiros_ativos); end
    for (int i = 0; i < 4; i++) begin
      bus.endereco_leitura = 2'(i); #1;
      n_cmp++;
      if ({bus.tiro_renderizado, bus.posicao_tiro} !== 9'h000) begin
        n_bad++; $display("FAIL reset_slot%0d: got %h required 000", i, {bus.tiro_renderizado, bus.posicao_tiro});
      end
    end
    @(negedge clock); reset = 1'b1;
    @(posedge clock); @(posedge clock); @(negedge clock);
    n_cmp++; if (bus.db_estado !== 4'd1) begin n_bad++; $display("FAIL reset_to_espera: got %0d required 1", bus.db_estado); end
  endtask

  task automatic test_spawn();
    logic desc; logic [3:0] st;
    spawn(4'd5, 4'd5, 2'b00, desc, st);
    n_cmp++; if (st !== 4'd2) begin n_bad++; $display("FAIL spawn_state: got %0d required 2", st); end
    n_cmp++; if (desc !== 1'b0) begin n_bad++; $display("FAIL spawn_desc: got %b required 0", desc); end
    n_cmp++; if (bus.db_estado !== 4'd1) begin n_bad++; $display("FAIL spawn_back: got %0d required 1", bus.db_estado); end
    bus.endereco_leitura = 2'd0; #1;
    n_cmp++; if ({bus.tiro_renderizado, bus.posicao_tiro} !== 9'h155) begin n_bad++; $display("FAIL spawn_slot0: got %h required 155", {bus.tiro_renderizado, bus.posicao_tiro}); end
    n_cmp++; if (bus.tiros_ativos !== 3'd1) begin n_bad++; $display("FAIL spawn_ativos: got %0d required 1", bus.tiros_ativos); end
  endtask

  task automatic test_move();
    int lat;
    run_pass(lat);
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL move_latency: got %0d required 10", lat); end
    @(negedge clock);
    n_cmp++; if (bus.fim_movimento !== 1'b0) begin n_bad++; $display("FAIL move_fim_pulse: got %b required 0", bus.fim_movimento); end
    n_cmp++; if (bus.db_estado !== 4'd1) begin n_bad++; $display("FAIL move_back: got %0d required 1", bus.db_estado); end
    bus.endereco_leitura = 2'd0; #1;
    n_cmp++; if ({bus.tiro_renderizado, bus.posicao_tiro} !== 9'h154) begin n_bad++; $display("FAIL move_slot0: got %h required 154", {bus.tiro_renderizado, bus.posicao_tiro}); end
    for (int i = 1; i < 4; i++) begin
      bus.endereco_leitura = 2'(i); #1;
      n_cmp++; if (bus.tiro_renderizado !== 1'b0) begin n_bad++; $display("FAIL move_idle_slot%0d: got %b required 0", i, bus.tiro_renderizado); end
    end
  endtask

  // One shot per field edge, each heading outward; all retire in place.
  task automatic test_edges();
    logic desc; logic [3:0] st; int lat;
    logic [8:0] exp [4] = '{9'h003, 9'h0F7, 9'h07F, 9'h090};
    do_reset();
    spawn(4'd0,  4'd3,  2'b11, desc, st);
    spawn(4'd15, 4'd7,  2'b01, desc, st);
    spawn(4'd7,  4'd15, 2'b10, desc, st);
    spawn(4'd9,  4'd0,  2'b00, desc, st);
    n_cmp++; if (bus.tiros_ativos !== 3'd4) begin n_bad++; $display("FAIL edges_loaded: got %0d required 4", bus.tiros_ativos); end
    run_pass(lat);
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL edges_latency: got %0d required 10", lat); end
    for (int i = 0; i < 4; i++) begin
      bus.endereco_leitura = 2'(i); #1;
      n_cmp++;
      if ({bus.tiro_renderizado, bus.posicao_tiro} !== exp[i]) begin
        n_bad++; $display("FAIL edges_slot%0d: got %h required %h", i, {bus.tiro_renderizado, bus.posicao_tiro}, exp[i]);
      end
    end
    n_cmp++; if (bus.tiros_ativos !== 3'd0) begin n_bad++; $display("FAIL edges_ativos: got %0d required 0", bus.tiros_ativos); end
  endtask

  task automatic test_full();
    logic desc; logic [3:0] st;
    logic [8:0] exp [4] = '{9'h111, 9'h122, 9'h133, 9'h144};
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      spawn(4'(i), 4'(i), 2'b01, desc, st);
      n_cmp++; if (desc !== 1'b0) begin n_bad++; $display("FAIL full_spawn%0d_desc: got %b required 0", i, desc); end
    end
    spawn(4'd9, 4'd9, 2'b00, desc, st);
    n_cmp++; if (desc !== 1'b1) begin n_bad++; $display("FAIL full_reject: got %b required 1", desc); end
    n_cmp++; if (bus.tiro_descartado !== 1'b0) begin n_bad++; $display("FAIL full_reject_pulse: got %b required 0", bus.tiro_descartado); end
    n_cmp++; if (bus.tiros_ativos !== 3'd4) begin n_bad++; $display("FAIL full_ativos: got %0d required 4", bus.tiros_ativos); end
    for (int i = 0; i < 4; i++) begin
      bus.endereco_leitura = 2'(i); #1;
      n_cmp++;
      if ({bus.tiro_renderizado, bus.posicao_tiro} !== exp[i]) begin
        n_bad++; $display("FAIL full_slot%0d: got %h required %h", i, {bus.tiro_renderizado, bus.posicao_tiro}, exp[i]);
      end
    end
  endtask

  // Slot 2 is on MOVE in the cycle after the 6th edge of the pass.
  task automatic test_clear_during_move();
    int lat;
    logic [8:0] exp [4] = '{9'h121, 9'h132, 9'h000, 9'h154};
    @(negedge clock);
    bus.iniciar_movimento = 1'b1;
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clock); @(negedge clock);
      if (c == 6) begin
        n_cmp++; if (bus.db_estado !== 4'd4) begin n_bad++; $display("FAIL clear_on_move_state: got %0d required 4", bus.db_estado); end
        bus.apaga_tiro = 1'b1;
        bus.endereco_leitura = 2'd2;
      end
      if (c == 7) bus.apaga_tiro = 1'b0;
      if (bus.fim_movimento) begin lat = c; break; end
    end
    bus.iniciar_movimento = 1'b0;
    bus.apaga_tiro = 1'b0;
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL clear_latency: got %0d required 10", lat); end
    for (int i = 0; i < 4; i++) begin
      bus.endereco_leitura = 2'(i); #1;
      n_cmp++;
      if (i == 2) begin
        if (bus.tiro_renderizado !== 1'b0) begin n_bad++; $display("FAIL clear_slot2_flag: got %b required 0", bus.tiro_renderizado); end
      end else if ({bus.tiro_renderizado, bus.posicao_tiro} !== exp[i]) begin
        n_bad++; $display("FAIL clear_slot%0d: got %h required %h", i, {bus.tiro_renderizado, bus.posicao_tiro}, exp[i]);
      end
    end
    n_cmp++; if (bus.tiros_ativos !== 3'd3) begin n_bad++; $display("FAIL clear_ativos: got %0d required 3", bus.tiros_ativos); end
  endtask

  task automatic test_reset_mid_pass();
    logic fim_seen;
    @(negedge clock);
    bus.iniciar_movimento = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clock); @(negedge clock);
    end
    n_cmp++; if (bus.db_estado !== 4'd4) begin n_bad++; $display("FAIL midreset_in_move: got %0d required 4", bus.db_estado); end
    reset = 1'b0;
    bus.iniciar_movimento = 1'b0;
    #1;
    n_cmp++; if (bus.tiros_ativos !== 3'd0) begin n_bad++; $display("FAIL midreset_ativos: got %0d required 0", bus.tiros_ativos); end
    n_cmp++; if (bus.db_estado !== 4'd0) begin n_bad++; $display("FAIL midreset_state: got %0d required 0", bus.db_estado); end
    @(negedge clock); reset = 1'b1;
    fim_seen = 1'b0;
    @(posedge clock); @(negedge clock);
    fim_seen |= bus.fim_movimento;
    @(posedge clock); @(negedge clock);
    fim_seen |= bus.fim_movimento;
    n_cmp++; if (bus.db_estado !== 4'd1) begin n_bad++; $display("FAIL midreset_espera: got %0d required 1", bus.db_estado); end
    for (int c = 0; c < 12; c++) begin
      @(posedge clock); @(negedge clock);
      fim_seen |= bus.fim_movimento;
    end
    n_cmp++; if (fim_seen !== 1'b0) begin n_bad++; $display("FAIL midreset_no_fim: got %b required 0", fim_seen); end
    for (int i = 0; i < 4; i++) begin
      bus.endereco_leitura = 2'(i); #1;
      n_cmp++; if (bus.tiro_renderizado !== 1'b0) begin n_bad++; $display("FAIL midreset_slot%0d: got %b required 0", i, bus.tiro_renderizado); end
    end
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_move();
    test_edges();
    test_full();
    test_clear_during_move();
    test_reset_mid_pass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
